// File: rtl/host_regs_pkg.sv
// Shared constants for the host register block: register offsets, CTRL/STATUS
// bit positions and the block ID value.
package host_regs_pkg;

  localparam logic [7:0] REG_CTRL       = 8'h00;
  localparam logic [7:0] REG_STATUS     = 8'h04;
  localparam logic [7:0] REG_CMD_PUSH   = 8'h08;
  localparam logic [7:0] REG_STATUS_CLR = 8'h0C;
  localparam logic [7:0] REG_SCRATCH    = 8'h10;
  localparam logic [7:0] REG_ID         = 8'h14;

  localparam int CTRL_ENABLE_BIT = 0;
  localparam int CTRL_SRST_BIT   = 1;
  localparam int CTRL_IRQ_EN_BIT = 2;

  localparam int ST_EMPTY_BIT = 0;
  localparam int ST_FULL_BIT  = 1;
  localparam int ST_BUSY_BIT  = 2;
  localparam int ST_OVF_BIT   = 3;
  localparam int ST_DONE_BIT  = 4;
  localparam int ST_LEVEL_LSB = 8;

  localparam logic [31:0] HOST_ID = 32'h4750_0001;

endpackage

// File: rtl/cmd_sync_fifo.sv
// Single-clock command FIFO with synchronous flush; a push while full is
// accepted when a pop happens in the same cycle.
module cmd_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  input  logic                       flush,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    cnt;
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (cnt == '0);
  assign full    = (cnt == LW'(DEPTH));
  assign level   = cnt;
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  // Head is forced to zero when empty so the output is defined out of reset.
  assign rdata   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok && !flush) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/host_bus_regs.sv
// Host register block: CTRL/STATUS/SCRATCH/ID registers plus a command FIFO.
// Define HOST_REGS_IRQ_EN to include the done_pending/irq_en/o_irq logic.
module host_bus_regs
  import host_regs_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_bus_we,
  input  logic [ADDR_WIDTH-1:0] i_bus_addr,
  input  logic [DATA_WIDTH-1:0] i_bus_wdata,
  output logic [DATA_WIDTH-1:0] o_bus_rdata,
  output logic                  o_cmd_valid,
  input  logic                  i_cmd_ready,
  output logic [DATA_WIDTH-1:0] o_cmd_data,
  output logic                  o_gpu_enable,
  output logic                  o_soft_reset,
  input  logic                  i_gpu_busy,
  output logic                  o_irq
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic [7:0]            reg_off;
  logic                  unused_addr_bits;
  logic                  wr_ctrl, wr_push, wr_clr, wr_scratch;
  logic                  soft_rst_req;
  logic                  enable_q, soft_rst_q, ovf_q;
  logic [DATA_WIDTH-1:0] scratch_q;
  logic                  fifo_full, fifo_empty;
  logic [LW-1:0]         fifo_level;
  logic                  ovf_set;
  logic                  irq_en_q, done_q;
  logic [DATA_WIDTH-1:0] ctrl_word, status_word;

  assign reg_off          = {i_bus_addr[7:2], 2'b00};
  assign unused_addr_bits = ^{i_bus_addr[ADDR_WIDTH-1:8], i_bus_addr[1:0]};

  assign wr_ctrl      = i_bus_we & (reg_off == REG_CTRL);
  assign wr_push      = i_bus_we & (reg_off == REG_CMD_PUSH);
  assign wr_clr       = i_bus_we & (reg_off == REG_STATUS_CLR);
  assign wr_scratch   = i_bus_we & (reg_off == REG_SCRATCH);
  assign soft_rst_req = wr_ctrl & i_bus_wdata[CTRL_SRST_BIT];

  // Full implies non-empty, so a ready consumer always frees a slot this cycle.
  assign ovf_set = wr_push & fifo_full & ~i_cmd_ready;

  cmd_sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_cmd_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wr_push),
    .wdata (i_bus_wdata),
    .pop   (i_cmd_ready),
    .flush (soft_rst_req),
    .rdata (o_cmd_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign o_cmd_valid  = ~fifo_empty;
  assign o_gpu_enable = enable_q;
  assign o_soft_reset = soft_rst_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enable_q   <= 1'b0;
      soft_rst_q <= 1'b0;
      ovf_q      <= 1'b0;
      scratch_q  <= '0;
    end else begin
      soft_rst_q <= soft_rst_req;
      if (wr_ctrl)    enable_q  <= i_bus_wdata[CTRL_ENABLE_BIT];
      if (wr_scratch) scratch_q <= i_bus_wdata;
      if (soft_rst_req)                         ovf_q <= 1'b0;
      else if (ovf_set)                         ovf_q <= 1'b1;
      else if (wr_clr && i_bus_wdata[ST_OVF_BIT]) ovf_q <= 1'b0;
    end
  end

`ifdef HOST_REGS_IRQ_EN
  logic busy_q;
  logic done_set;

  assign done_set = busy_q & ~i_gpu_busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_en_q <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      busy_q <= i_gpu_busy;
      if (wr_ctrl) irq_en_q <= i_bus_wdata[CTRL_IRQ_EN_BIT];
      if (soft_rst_req)                          done_q <= 1'b0;
      else if (done_set)                         done_q <= 1'b1;
      else if (wr_clr && i_bus_wdata[ST_DONE_BIT]) done_q <= 1'b0;
    end
  end

  assign o_irq = irq_en_q & (done_q | ovf_q);
`else
  assign irq_en_q = 1'b0;
  assign done_q   = 1'b0;
  assign o_irq    = 1'b0;
`endif

  always_comb begin
    ctrl_word                  = '0;
    ctrl_word[CTRL_ENABLE_BIT] = enable_q;
    ctrl_word[CTRL_IRQ_EN_BIT] = irq_en_q;
  end

  // Level field is 8 bits wide; at depth 256 a full FIFO reads level 0 with full set.
  always_comb begin
    status_word                      = '0;
    status_word[ST_EMPTY_BIT]        = fifo_empty;
    status_word[ST_FULL_BIT]         = fifo_full;
    status_word[ST_BUSY_BIT]         = i_gpu_busy;
    status_word[ST_OVF_BIT]          = ovf_q;
    status_word[ST_DONE_BIT]         = done_q;
    status_word[ST_LEVEL_LSB +: 8]   = 8'(fifo_level);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_bus_rdata <= '0;
    end else begin
      case (reg_off)
        REG_CTRL:    o_bus_rdata <= ctrl_word;
        REG_STATUS:  o_bus_rdata <= status_word;
        REG_SCRATCH: o_bus_rdata <= scratch_q;
        REG_ID:      o_bus_rdata <= DATA_WIDTH'(HOST_ID);
        default:     o_bus_rdata <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_host_bus_regs.sv
// Directed self-checking bench for host_bus_regs; expected values are hand-computed.
// Expectations for irq/done_pending follow whether HOST_REGS_IRQ_EN is defined.
module tb_host_bus_regs;
  import host_regs_pkg::*;

`ifdef HOST_REGS_IRQ_EN
  localparam logic IRQ_BUILD = 1'b1;
`else
  localparam logic IRQ_BUILD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_bus_we = 1'b0;
  logic [31:0] i_bus_addr = '0;
  logic [31:0] i_bus_wdata = '0;
  logic [31:0] o_bus_rdata;
  logic        o_cmd_valid;
  logic        i_cmd_ready = 1'b0;
  logic [31:0] o_cmd_data;
  logic        o_gpu_enable;
  logic        o_soft_reset;
  logic        i_gpu_busy = 1'b0;
  logic        o_irq;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] rd;
  logic [31:0] exp_q[$];

  host_bus_regs dut (
    .clk          (clk),
    .rst          (rst),
    .i_bus_we     (i_bus_we),
    .i_bus_addr   (i_bus_addr),
    .i_bus_wdata  (i_bus_wdata),
    .o_bus_rdata  (o_bus_rdata),
    .o_cmd_valid  (o_cmd_valid),
    .i_cmd_ready  (i_cmd_ready),
    .o_cmd_data   (o_cmd_data),
    .o_gpu_enable (o_gpu_enable),
    .o_soft_reset (o_soft_reset),
    .i_gpu_busy   (i_gpu_busy),
    .o_irq        (o_irq)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    i_bus_we    = 1'b1;
    i_bus_addr  = addr;
    i_bus_wdata = data;
    tick();
    i_bus_we    = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
    i_bus_addr = addr;
    tick();
    data = o_bus_rdata;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_eq("rst_valid",  {31'b0, o_cmd_valid},  32'h0);
    chk_eq("rst_irq",    {31'b0, o_irq},        32'h0);
    chk_eq("rst_enable", {31'b0, o_gpu_enable}, 32'h0);
    chk_eq("rst_srst",   {31'b0, o_soft_reset}, 32'h0);
    chk_eq("rst_rdata",  o_bus_rdata,           32'h0);
    rst = 1'b0;
    tick();

    bus_read(32'h14, rd); chk_eq("id", rd, 32'h4750_0001);
    bus_read(32'h04, rd); chk_eq("status_reset", rd, 32'h0000_0001);
    bus_read(32'h10, rd); chk_eq("scratch_reset", rd, 32'h0);

    // three words, consumer stalled
    bus_write(32'h08, 32'hA1);
    bus_write(32'h08, 32'hA2);
    bus_write(32'h08, 32'hA3);
    bus_read(32'h04, rd); chk_eq("status_lvl3", rd, 32'h0000_0300);
    chk_eq("head_a1_valid", {31'b0, o_cmd_valid}, 32'h1);
    i_cmd_ready = 1'b1;
    chk_eq("pop_a1", o_cmd_data, 32'hA1);
    tick(); chk_eq("pop_a2", o_cmd_data, 32'hA2);
    tick(); chk_eq("pop_a3", o_cmd_data, 32'hA3);
    tick(); chk_eq("drained_valid", {31'b0, o_cmd_valid}, 32'h0);
    i_cmd_ready = 1'b0;

    // overflow with irq_en requested
    bus_write(32'h00, 32'h5);
    chk_eq("enable_on", {31'b0, o_gpu_enable}, 32'h1);
    bus_read(32'h00, rd); chk_eq("ctrl_rd", rd, IRQ_BUILD ? 32'h5 : 32'h1);
    for (int i = 0; i < 17; i++) bus_write(32'h08, 32'h100 + i);
    bus_read(32'h04, rd); chk_eq("status_ovf", rd, 32'h0000_100A);
    chk_eq("irq_ovf", {31'b0, o_irq}, {31'b0, IRQ_BUILD});
    bus_write(32'h0C, 32'h8);
    bus_read(32'h04, rd); chk_eq("status_ovf_clr", rd, 32'h0000_1002);
    chk_eq("irq_ovf_clr", {31'b0, o_irq}, 32'h0);

    // push while full and popping is accepted
    i_cmd_ready = 1'b1;
    bus_write(32'h08, 32'h55);
    i_cmd_ready = 1'b0;
    bus_read(32'h04, rd); chk_eq("status_push_pop_full", rd, 32'h0000_1002);
    for (int i = 1; i < 16; i++) exp_q.push_back(32'h100 + i);
    exp_q.push_back(32'h55);
    i_cmd_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk_eq($sformatf("drain_%0d", i), o_cmd_data, exp_q[i]);
      tick();
    end
    i_cmd_ready = 1'b0;
    chk_eq("drain_empty", {31'b0, o_cmd_valid}, 32'h0);

    // register read/write ordering and unmapped addresses
    bus_write(32'h10, 32'h1234);
    bus_write(32'h10, 32'hBEEF);
    chk_eq("scratch_old_same_cycle", o_bus_rdata, 32'h1234);
    tick(); chk_eq("scratch_new", o_bus_rdata, 32'hBEEF);
    bus_write(32'h20, 32'hFFFF_FFFF);
    bus_read(32'h20, rd); chk_eq("unmapped_rd", rd, 32'h0);
    bus_read(32'h08, rd); chk_eq("push_reg_rd", rd, 32'h0);

    // busy falling edge -> done_pending (only in the irq build)
    i_gpu_busy = 1'b1;
    bus_read(32'h04, rd); chk_eq("status_busy", rd, 32'h0000_0005);
    i_gpu_busy = 1'b0;
    tick();
    bus_read(32'h04, rd); chk_eq("status_done", rd, IRQ_BUILD ? 32'h11 : 32'h01);
    chk_eq("irq_done", {31'b0, o_irq}, {31'b0, IRQ_BUILD});
    i_gpu_busy = 1'b1;
    tick(); tick();
    i_gpu_busy = 1'b0;
    bus_write(32'h0C, 32'h10);
    bus_read(32'h04, rd); chk_eq("done_set_wins", rd, IRQ_BUILD ? 32'h11 : 32'h01);
    bus_write(32'h0C, 32'h10);
    bus_read(32'h04, rd); chk_eq("done_clr", rd, 32'h01);
    chk_eq("irq_done_clr", {31'b0, o_irq}, 32'h0);

    // soft reset with five queued words
    bus_write(32'h10, 32'h1234);
    for (int i = 0; i < 5; i++) bus_write(32'h08, 32'hC0 + i);
    bus_read(32'h04, rd); chk_eq("status_lvl5", rd, 32'h0000_0500);
    bus_write(32'h00, 32'h3);
    chk_eq("srst_pulse", {31'b0, o_soft_reset}, 32'h1);
    chk_eq("srst_flush", {31'b0, o_cmd_valid}, 32'h0);
    tick();
    chk_eq("srst_one_cycle", {31'b0, o_soft_reset}, 32'h0);
    bus_read(32'h04, rd); chk_eq("srst_status", rd, 32'h0000_0001);
    bus_read(32'h10, rd); chk_eq("srst_scratch", rd, 32'h1234);
    bus_read(32'h00, rd); chk_eq("srst_ctrl", rd, 32'h1);
    chk_eq("srst_enable", {31'b0, o_gpu_enable}, 32'h1);

    // async reset mid-stream clears queued words
    bus_write(32'h08, 32'h77);
    #2 rst = 1'b1;
    #1;
    chk_eq("async_rst_valid", {31'b0, o_cmd_valid}, 32'h0);
    chk_eq("async_rst_enable", {31'b0, o_gpu_enable}, 32'h0);
    rst = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
